// File: rtl/coin_acceptor_pkg.sv
// Shared types and default timing constants for the coin acceptor front-end.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_JAM     = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam int unsigned DEF_MIN_W    = 3;
  localparam int unsigned DEF_MAX_W    = 20;
  localparam int unsigned DEF_GAP_W    = 4;
  localparam int unsigned DEF_CREDIT_W = 3;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module coin_acceptor_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-mech front-end: width-validates sensor pulses, banks credit and
// releases one coin strobe per turnstile lock cycle.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned MIN_W    = DEF_MIN_W,
  parameter int unsigned MAX_W    = DEF_MAX_W,
  parameter int unsigned GAP_W    = DEF_GAP_W,
  parameter int unsigned CREDIT_W = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_sense,
  input  logic                locked,
  output logic                coin,
  output logic                reject,
  output logic                jam,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned WCNT_W = cnt_bits(MAX_W + 1);
  localparam int unsigned GCNT_W = cnt_bits(GAP_W);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  logic s;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                holdoff_q, holdoff_d;
  logic                coin_q, coin_d;
  logic                reject_q, reject_d;
  logic                jam_q, jam_d;

  logic                coin_ok;
  logic                jam_hit;
  logic                dispatch;
  logic                overflow;
  logic [CREDIT_W-1:0] credit_eff;

  coin_acceptor_sync2 #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (coin_sense),
    .q  (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      gcnt_q    <= '0;
      credit_q  <= '0;
      holdoff_q <= 1'b0;
      coin_q    <= 1'b0;
      reject_q  <= 1'b0;
      jam_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      gcnt_q    <= gcnt_d;
      credit_q  <= credit_d;
      holdoff_q <= holdoff_d;
      coin_q    <= coin_d;
      reject_q  <= reject_d;
      jam_q     <= jam_d;
    end
  end

  // Pulse measurement FSM; coin_ok/jam_hit flag the classifying edge.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    coin_ok = 1'b0;
    jam_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_MEASURE;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (s) begin
          if (wcnt_q >= WCNT_W'(MAX_W)) begin
            state_d = ST_JAM;
            wcnt_d  = WCNT_W'(MAX_W + 1);
            jam_hit = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else begin
          coin_ok = (wcnt_q >= WCNT_W'(MIN_W));
          state_d = ST_GAP;
          gcnt_d  = GCNT_W'(GAP_W);
        end
      end
      ST_JAM: begin
        if (!s) begin
          state_d = ST_GAP;
          gcnt_d  = GCNT_W'(GAP_W);
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit bank: dispatch is netted out before the overflow test so a
  // strobe on the same edge frees the slot for the incoming coin.
  always_comb begin
    dispatch   = (credit_q != '0) && locked && !holdoff_q;
    credit_eff = credit_q - CREDIT_W'(dispatch);
    credit_d   = credit_eff;
    overflow   = 1'b0;
    if (coin_ok) begin
      if (credit_eff == CREDIT_MAX) begin
        overflow = 1'b1;
      end else begin
        credit_d = credit_eff + CREDIT_W'(1);
      end
    end

    holdoff_d = holdoff_q;
    if (!locked) begin
      holdoff_d = 1'b0;
    end else if (dispatch) begin
      holdoff_d = 1'b1;
    end

    coin_d   = dispatch;
    reject_d = jam_hit | overflow;
    jam_d    = (state_d == ST_JAM);
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign credit = credit_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: strobes are matched in order against
// hand-computed expectations; levels are checked directly at fixed points.
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;

  localparam int unsigned CW = DEF_CREDIT_W;

  typedef struct packed {
    logic          is_coin;
    logic [CW-1:0] credit;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin_sense;
  logic          locked;
  logic          coin;
  logic          reject;
  logic          jam;
  logic [CW-1:0] credit;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  coin_acceptor #(
    .MIN_W   (3),
    .MAX_W   (20),
    .GAP_W   (4),
    .CREDIT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin_sense(coin_sense),
    .locked    (locked),
    .coin      (coin),
    .reject    (reject),
    .jam       (jam),
    .credit    (credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      coin_sense = 1'b1;
    end
    @(negedge clk);
    coin_sense = 1'b0;
  endtask

  task automatic coin_in(input int n);
    pulse(n);
    tick(12);
  endtask

  task automatic push_ev(input logic is_coin, input int cr);
    ev_t e;
    e.is_coin = is_coin;
    e.credit  = CW'(cr);
    exp_q.push_back(e);
  endtask

  // Pops one expectation for every strobe the DUT presents.
  task automatic monitor();
    ev_t        e;
    logic [1:0] kind;
    forever begin
      @(negedge clk);
      if (!rst && (coin || reject)) begin
        kind = {coin, reject};
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", int'(kind), 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", int'(kind), e.is_coin ? 2 : 1);
          check("strobe_credit", int'(credit), int'(e.credit));
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    coin_sense = 1'b0;
    locked     = 1'b1;
    fork
      monitor();
    join_none

    tick(3);
    check("rst_coin", int'(coin), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_credit", int'(credit), 0);
    rst = 1'b0;

    // Valid 8-cycle coin with gate locked: bank then dispatch next edge.
    push_ev(1'b1, 0);
    pulse(8);
    tick(3);
    check("t1_credit_banked", int'(credit), 1);
    check("t1_no_coin_yet", int'(coin), 0);
    tick(1);
    check("t1_credit_after_coin", int'(credit), 0);
    tick(12);

    // Glitch below MIN_W, then a minimum-width coin.
    pulse(2);
    tick(12);
    check("t2_glitch_credit", int'(credit), 0);
    locked = 1'b0;
    tick(1);
    coin_in(3);
    check("t2_min_width_credit", int'(credit), 1);

    // 25-cycle hold: one reject on jam entry, jam level until release.
    push_ev(1'b0, 1);
    pulse(25);
    check("t3_jam_high", int'(jam), 1);
    tick(3);
    check("t3_jam_released", int'(jam), 0);
    check("t3_credit_kept", int'(credit), 1);
    tick(12);
    coin_in(20);
    check("t3_max_width_valid", int'(credit), 2);
    check("t3_max_width_nojam", int'(jam), 0);

    // Banked credit released one strobe per lock cycle.
    coin_in(5);
    check("t4_credit3", int'(credit), 3);
    push_ev(1'b1, 2);
    locked = 1'b1;
    tick(3);
    check("t4_after_strobe", int'(credit), 2);
    tick(6);
    check("t4_holdoff_blocks", int'(credit), 2);
    push_ev(1'b1, 1);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(3);
    check("t4_second_strobe", int'(credit), 1);
    locked = 1'b0;
    tick(2);

    // Saturation at 7, overflow reject, then dispatch on the same edge.
    repeat (6) coin_in(4);
    check("t5_full", int'(credit), 7);
    push_ev(1'b0, 7);
    coin_in(4);
    check("t5_overflow_hold", int'(credit), 7);
    push_ev(1'b1, 7);
    pulse(3);
    tick(2);
    locked = 1'b1;
    tick(1);
    check("t5_same_edge_credit", int'(credit), 7);
    check("t5_same_edge_noreject", int'(reject), 0);
    locked = 1'b0;
    tick(12);

    // Asynchronous reset in the middle of a measurement with credit 2.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_cleared", int'(credit), 0);
    coin_in(4);
    coin_in(4);
    check("t6_credit2", int'(credit), 2);
    @(negedge clk);
    coin_sense = 1'b1;
    tick(6);
    #2 rst = 1'b1;
    #1;
    check("t6_async_credit", int'(credit), 0);
    check("t6_async_coin", int'(coin), 0);
    check("t6_async_reject", int'(reject), 0);
    check("t6_async_jam", int'(jam), 0);
    coin_sense = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(12);
    check("t6_post_reset_credit", int'(credit), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
